// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared EX-stage types and constants for the divide controller
package ex_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BYZERO,
        DIV_ON,
        DIV_END
    } div_state_e;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring divide iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted;

    always_comb begin
        // The dividend is shifted out of quo MSB-first while quotient bits enter at the LSB
        shifted = {rem, quo[WIDTH-1]};
        if (shifted >= {2'b00, divisor}) begin
            rem_next = shifted[WIDTH:0] - {1'b0, divisor};
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - multi-cycle DIV/DIVU controller producing {remainder, quotient}
module ex_div_ctrl
    import ex_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_req_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem, rem_nx;
    logic [WIDTH-1:0] quo, quo_nx;
    logic [WIDTH-1:0] divisor;
    logic             neg_quo, neg_rem;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic             last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // -2^(W-1) negates to itself, which is exactly its unsigned magnitude
    assign dividend_mag = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign divisor_mag  = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign last_step    = (count == CW'(WIDTH - 1));

    assign ready_o     = (state == DIV_END);
    assign stall_req_o = start_i & ~ready_o & ~annul_i;

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE:   if (start_i) state_next = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
            DIV_BYZERO: state_next = DIV_END;
            DIV_ON:     if (last_step) state_next = DIV_END;
            DIV_END:    if (!start_i) state_next = DIV_IDLE;
            default:    state_next = DIV_IDLE;
        endcase
        if (annul_i) state_next = DIV_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= DIV_IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
        end else if (annul_i) begin
            state    <= DIV_IDLE;
            count    <= '0;
            result_o <= '0;
        end else begin
            state <= state_next;
            case (state)
                DIV_IDLE: if (start_i) begin
                    rem     <= '0;
                    quo     <= dividend_mag;
                    divisor <= divisor_mag;
                    neg_quo <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem <= signed_i & opdata1_i[WIDTH-1];
                    count   <= '0;
                end
                DIV_BYZERO: result_o <= '0;
                DIV_ON: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    count <= count + 1'b1;
                    if (last_step)
                        result_o <= {neg_rem ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0],
                                     neg_quo ? -quo_nx : quo_nx};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - self-checking bench for ex_div_ctrl
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        annul = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] exp_result = '0;

    ex_div_ctrl #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start),
        .signed_i    (sgn),
        .opdata1_i   (op1),
        .opdata2_i   (op2),
        .annul_i     (annul),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Architectural reference: truncating division, remainder follows the dividend
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (!s) return {a % b, a / b};
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_i) begin
            check("stall_eq", stall_req_o, start & ~ready_o & ~annul);
            if (ready_o) check("result_vs_model", result_o, exp_result);
        end
    end

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [63:0] lit, input string name);
        logic [63:0] held;
        int lat;
        sgn = s; op1 = a; op2 = b; start = 1'b1;
        exp_result = model(s, a, b);
        check({name, "_model"}, exp_result, lit);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin op1 = $urandom; op2 = $urandom; end
            if (ready_o) begin lat = i; break; end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_result"}, result_o, lit);
        held = result_o;
        repeat (3) begin
            @(posedge clk); #1;
            check({name, "_ready_hold"}, ready_o, 1'b1);
            check({name, "_result_hold"}, result_o, held);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check({name, "_ready_drop"}, ready_o, 1'b0);
    endtask

    task automatic watch_no_ready(input string name);
        int seen;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", ready_o, 1'b0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", stall_req_o, 1'b0);
        rst_i = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset while the divide is at count 10
        sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("midop_reset_ready", ready_o, 1'b0);
        check("midop_reset_result", result_o, 64'd0);
        start = 1'b0;
        @(posedge clk); #1;
        check("midop_reset_ready_edge", ready_o, 1'b0);
        rst_i = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "divu_after_reset");

        run_op(1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "divu_100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, "div_ovf");
        run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'd14}, "div_m100_m7");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF}, "divu_max_1");
        run_op(1'b0, 32'd5, 32'd9, 33, {32'd5, 32'd0}, "divu_5_9");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'd0}, "divu_big");
        run_op(1'b0, 32'h1234, 32'd0, 2, 64'd0, "divu_by_zero");
        run_op(1'b1, 32'h1234, 32'd0, 2, 64'd0, "div_by_zero");

        // Annul at count 5
        sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        exp_result = model(1'b0, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        check("annul_ready", ready_o, 1'b0);
        check("annul_result", result_o, 64'd0);
        watch_no_ready("annul_no_ready");

        // Annul together with start while idle
        sgn = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
        #1;
        check("annul_start_stall", stall_req_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("annul_start_ready", ready_o, 1'b0);
        start = 1'b0; annul = 1'b0;
        watch_no_ready("annul_start_idle");

        run_op(1'b1, 32'd50, 32'hFFFF_FFFB, 33, {32'd0, 32'hFFFF_FFF6}, "div_after_annul");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
